// File: rtl/serial_subtractor_if.sv
// Handshake and result bundle for the bit-serial subtractor.
// The master drives the operands and start; the slave returns the result and status.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (output start, a, b, bin, input diff, bout, zero, busy, done);
  modport slave  (input start, a, b, bin, output diff, bout, zero, busy, done);
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// and presents a registered diff/bout/zero with a one-cycle done pulse.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q;

  logic             bit_d, br_d;
  logic [WIDTH-1:0] res_d;

  // One full-subtractor cell working on the current LSBs.
  assign bit_d = a_q[0] ^ b_q[0] ^ br_q;
  assign br_d  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  assign res_d = {bit_d, res_q[WIDTH-1:1]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state_q)
      SHIFT:   bus.busy = 1'b1;
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  // Datapath. The last SHIFT edge forwards the final bit straight into the
  // output registers so the result is visible in the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      bus.diff <= '0;
      bus.bout <= 1'b0;
      bus.zero <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            br_q  <= bus.bin;
            cnt_q <= '0;
          end
        end
        SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= br_d;
          res_q <= res_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            bus.diff <= res_d;
            bus.bout <= br_d;
            bus.zero <= (res_d == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
